// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Signed operations run on operand magnitudes, and the sign is fixed up in a final FIX cycle.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs_i,
    input  logic [DATA_WIDTH-1:0] rt_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2*W-1:0]   acc_q, acc_step;
    logic [W-1:0]     opnd_q, hi_q, lo_q;
    logic             is_div_q, neg_lo_q, neg_hi_q, div_zero_q, done_q;

    logic             accept, is_arith, signed_op, rs_neg, rt_neg;
    logic [W-1:0]     rs_mag, rt_mag;
    logic [W:0]       mul_sum, div_diff;
    logic [2*W:0]     div_shift;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     quo, rem, fix_hi, fix_lo;

    assign accept    = start_i && (state_q == StIdle) && !flush_i;
    assign is_arith  = !op_i[2];
    // Ops 0 (mult) and 2 (div) are the signed ones.
    assign signed_op = !op_i[0];
    assign rs_neg    = signed_op && rs_i[W-1];
    assign rt_neg    = signed_op && rt_i[W-1];
    assign rs_mag    = rs_neg ? -rs_i : rs_i;
    assign rt_mag    = rt_neg ? -rt_i : rt_i;

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, 1'b0};
        div_diff  = div_shift[2*W:W] - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_diff[W]) acc_step = {div_diff[W-1:0], div_shift[W-1:1], 1'b1};
            else              acc_step = div_shift[2*W-1:0];
        end else begin
            acc_step = {mul_sum, acc_q[W-1:1]};
        end
    end

    // Sign correction; a zero divisor forces an all-ones quotient.
    always_comb begin
        prod   = neg_lo_q ? -acc_q : acc_q;
        quo    = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem    = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        fix_hi = is_div_q ? rem : prod[2*W-1:W];
        fix_lo = is_div_q ? (div_zero_q ? '1 : quo) : prod[W-1:0];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && is_arith) state_d = StRun;
            StRun: begin
                if (flush_i)                             state_d = StIdle;
                else if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = StFix;
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Datapath: operand latch, iteration, HI/LO update and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (op_i)
                            3'd6: hi_q <= rs_i;
                            3'd7: lo_q <= rs_i;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div_q   <= op_i[1];
                                cnt_q      <= '0;
                                neg_lo_q   <= rs_neg ^ rt_neg;
                                neg_hi_q   <= op_i[1] ? rs_neg : (rs_neg ^ rt_neg);
                                div_zero_q <= op_i[1] && (rt_i == '0);
                                acc_q      <= {{W{1'b0}}, (op_i[1] ? rs_mag : rt_mag)};
                                opnd_q     <= op_i[1] ? rt_mag : rs_mag;
                            end
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    if (!flush_i) begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFix: begin
                    if (!flush_i) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // mfhi/mflo read port.
    always_comb begin
        result_o = '0;
        case (op_i)
            3'd4:    result_o = hi_q;
            3'd5:    result_o = lo_q;
            default: ;
        endcase
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits in the EX stage beside the ALU and consumes the ID/EX pipeline outputs: decoded operation, rs value and rt value.
- Implements mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Asserts busy_o while an iteration is in progress so hazard logic can stall IF/ID/EX.

Parameters:
- DATA_WIDTH, 32, operand, HI and LO width. The iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  operation request from the EX stage.
- op_i  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo.
- rs_i  input  DATA_WIDTH  rs operand: multiplicand, dividend, or the mthi/mtlo source.
- rt_i  input  DATA_WIDTH  rt operand: multiplier or divisor.
- flush_i  input  1  abort the in-flight operation (branch squash).
- busy_o  output  1  iteration in progress; EX must stall.
- done_o  output  1  one-cycle pulse when HI/LO take a mult/div result.
- result_o  output  DATA_WIDTH  mfhi/mflo read data, combinational.
- hi_o  output  DATA_WIDTH  HI register.
- lo_o  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - HI, LO, internal accumulators and the counter clear to 0.
  - busy_o=0, done_o=0.
  - Reset mid-operation discards all work.
- State machine: IDLE -> RUN -> FIX -> IDLE.
- Acceptance: an op is accepted at a rising edge when start_i=1, busy_o=0 and flush_i=0. start_i while busy_o=1 is ignored; the stalled EX stage holds the request.
- mthi/mtlo:
  - Write rs_i into HI/LO at the accept edge.
  - No busy cycle, no done_o.
- mfhi/mflo:
  - result_o = HI or LO combinationally whenever op_i selects them.
  - Otherwise result_o = 0.
  - Never sets busy.
- mult/multu/div/divu accept edge:
  - Latch operands and enter RUN with counter=0.
  - Signed ops store operand magnitudes plus the result signs: product sign = rs^rt, quotient sign = rs^rt, remainder sign = rs.
  - busy_o=1 from the accept edge until the FIX edge, i.e. 33 cycles (DATA_WIDTH+1).
- RUN, one iteration per cycle, counter increments:
  - Multiply: shift-add over a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After DATA_WIDTH iterations, go to FIX.
- FIX (one cycle):
  - Apply two's-complement sign correction.
  - Write HI/LO at the FIX edge: HI = product[63:32] / remainder, LO = product[31:0] / quotient.
  - done_o=1 for the following cycle; busy_o=0.
  - Return to IDLE.
- Divide by zero (rt=0):
  - Runs full latency.
  - LO = all ones, HI = rs_i (raw, unsigned view).
  - No exception raised.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. Magnitudes are handled as unsigned 32-bit values.
- flush_i:
  - Asserted in RUN or FIX, it returns the unit to IDLE at that edge.
  - HI/LO stay unchanged, no done_o, busy_o=0 the next cycle.
  - In IDLE it blocks acceptance.
- Back-to-back: a new start_i may be accepted in the cycle after the FIX edge.
- Width: multu/divu zero-extend; signed ops use |x| with 0x80000000 treated as 2^31.

Test Plan:
- Reset release, then mult rs=7, rt=6 -> busy_o high 33 cycles, done_o pulse; HI=0x00000000, LO=0x0000002A; mflo gives result_o=0x2A.
- mult rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0, LO=1. multu with same operands -> HI=0xFFFFFFFE, LO=0x00000001.
- div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu rs=100, rt=7 -> LO=14, HI=2.
- div rs=5, rt=0 -> 33-cycle latency, LO=0xFFFFFFFF, HI=5. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x1234 then mtlo 0x5678 on consecutive cycles -> no busy; hi_o=0x1234, lo_o=0x5678. start_i during busy -> ignored; HI/LO reflect the first op only.
- Start mult, flush_i at cycle 10 -> busy_o=0 the next cycle, HI/LO unchanged, no done_o. Start again and drop reset low at cycle 20 -> HI=LO=0, busy_o=0 immediately.
